// File: rtl/core_pkg.sv
// core_pkg: shared RV32I core constants, fetch FSM encoding and base opcodes
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage, one outstanding imem request, redirect with stale-response drain.
// Optional FETCH_MISALIGN_TRAP_EN adds fetch_misaligned_o and a FAULT state for misaligned redirects.
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR    = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instruction_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misaligned_o
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] tgt_pc;
    logic            bad_pc;
    logic            redir;
    logic            fault;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt_pc             = redirect_pc_i;
    assign bad_pc             = |redirect_pc_i[1:0];
    assign fetch_misaligned_o = mis_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc_i[1:0];
    assign tgt_pc          = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign bad_pc          = 1'b0;
`endif

    // once faulted, further redirects are ignored (also while draining toward FAULT)
    assign redir = redirect_valid_i && !mis_q;
    assign fault = redir && bad_pc;

    assign imem_req_o    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instruction_o = instr_q;
    assign instr_pc_o    = ipc_q;

    // next-state and datapath; redirect outranks ack and ready
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        case (state_q)
            ST_BOOT: begin
                state_d = fault ? ST_FAULT : ST_REQ;
                if (redir) pc_d = tgt_pc;
            end
            ST_REQ: begin
                if (redir) begin
                    pc_d = tgt_pc;
                    // ack+redirect returns via BOOT so req drops for exactly one cycle
                    state_d = !imem_ack_i ? ST_DRAIN : (fault ? ST_FAULT : ST_BOOT);
                end else if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + XLEN'(4);
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redir || instr_ready_i) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = fault ? ST_FAULT : ST_REQ;
                    if (redir) pc_d = tgt_pc;
                end
            end
            ST_DRAIN: begin
                if (redir) pc_d = tgt_pc;
                if (imem_ack_i) state_d = (mis_q || fault) ? ST_FAULT : ST_REQ;
            end
            default: ;
        endcase
        mis_d = mis_q | fault;
        if (state_d == ST_REQ) addr_d = pc_d;
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            addr_q  <= RESET_VECTOR;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed tests plus per-cycle transaction model for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instruction_o;
    logic [31:0] instr_pc_o;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned_o;
`endif

    int total;
    int bad;
    int lat;
    logic [31:0] xfer_pc[$];
    logic [31:0] xfer_data[$];
    logic [31:0] req_log[$];

    instruction_fetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ack_i        (imem_ack_i),
        .imem_rdata_i      (imem_rdata_i),
        .instr_valid_o     (instr_valid_o),
        .instr_ready_i     (instr_ready_i),
        .instruction_o     (instruction_o),
        .instr_pc_o        (instr_pc_o),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_pc_i     (redirect_pc_i)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned_o(fetch_misaligned_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'bx;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ok(input string nm, input int n);
        chk(nm, 32'(n < 200), 32'd1);
    endtask

    task automatic redir(input logic [31:0] a);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = a;
        tick;
        redirect_valid_i = 1'b0;
    endtask

    task automatic do_reset;
        tick;
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instruction_o, NOP);
        chk("rst_pc", instr_pc_o, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_mis", 32'(fetch_misaligned_o), 32'd0);
`endif
        instr_ready_i    = 1'b1;
        redirect_valid_i = 1'b0;
        lat = 0;
        tick;
        tick;
        xfer_pc.delete();
        xfer_data.delete();
        req_log.delete();
        rst_n = 1'b1;
    endtask

    // instruction memory: one ack per request after lat idle cycles, data derived from address
    initial begin
        int cnt;
        cnt = 0;
        imem_ack_i = 1'b0;
        imem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n || imem_ack_i) begin
                imem_ack_i = 1'b0;
                cnt = 0;
            end else if (imem_req_o) begin
                if (cnt >= lat) begin
                    imem_ack_i = 1'b1;
                    imem_rdata_i = memf(imem_addr_o);
                end else cnt++;
            end else cnt = 0;
        end
    end

    // transaction model: expected delivery PC sequence, hold stability, request protocol
    initial begin
        logic [31:0] exp_pc, p_instr, p_pc, p_addr;
        logic p_valid, p_ready, p_req, p_ack, p_redir;
        exp_pc = 0; p_instr = 0; p_pc = 0; p_addr = 0;
        p_valid = 0; p_ready = 0; p_req = 0; p_ack = 0; p_redir = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                exp_pc = 32'h0;
                p_valid = 0; p_ready = 0; p_req = 0; p_ack = 0; p_redir = 0;
            end else begin
                if (instr_valid_o) begin
                    chk("pc_seq", instr_pc_o, exp_pc);
                    chk("data", instruction_o, memf(instr_pc_o));
                end else chk("nop_idle", instruction_o, NOP);
                if (p_valid && !p_ready && !p_redir) begin
                    chk("hold_valid", 32'(instr_valid_o), 32'd1);
                    chk("hold_instr", instruction_o, p_instr);
                    chk("hold_pc", instr_pc_o, p_pc);
                end
                if (p_req && !p_ack) begin
                    chk("req_held", 32'(imem_req_o), 32'd1);
                    chk("addr_stable", imem_addr_o, p_addr);
                end
                if (p_redir && p_valid) chk("kill_valid", 32'(instr_valid_o), 32'd0);
                if (imem_req_o && (!p_req || p_ack)) req_log.push_back(imem_addr_o);
                if (instr_valid_o && instr_ready_i) begin
                    xfer_pc.push_back(instr_pc_o);
                    xfer_data.push_back(instruction_o);
                    exp_pc = instr_pc_o + 32'd4;
                end
                if (redirect_valid_i) exp_pc = redirect_pc_i;
                p_valid = instr_valid_o; p_ready = instr_ready_i; p_instr = instruction_o;
                p_pc = instr_pc_o; p_req = imem_req_o; p_ack = imem_ack_i;
                p_addr = imem_addr_o; p_redir = redirect_valid_i;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, held, r0, c;
        rst_n = 1'b0;
        instr_ready_i = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i = 32'h0;
        lat = 0;
        total = 0;
        bad = 0;

        // sequential fetch with zero-wait memory
        do_reset;
        n = 0;
        while (xfer_pc.size() < 3 && n < 200) begin tick; n++; end
        wait_ok("t1_wait", n);
        chk("t1_pc0", q_at(xfer_pc, 0), 32'h0);
        chk("t1_pc1", q_at(xfer_pc, 1), 32'h4);
        chk("t1_pc2", q_at(xfer_pc, 2), 32'h8);
        chk("t1_d0", q_at(xfer_data, 0), 32'hC0DE_0013);
        chk("t1_d1", q_at(xfer_data, 1), 32'hC0DE_0017);
        chk("t1_d2", q_at(xfer_data, 2), 32'hC0DE_001B);
        chk("t1_a0", q_at(req_log, 0), 32'h0);
        chk("t1_a1", q_at(req_log, 1), 32'h4);
        chk("t1_a2", q_at(req_log, 2), 32'h8);

        // backpressure on the instruction at 0x4
        do_reset;
        held = 0;
        n = 0;
        while (held < 5 && n < 200) begin
            if (instr_valid_o && instr_pc_o == 32'h4) begin
                instr_ready_i = 1'b0;
                held++;
                chk("t2_req_low", 32'(imem_req_o), 32'd0);
                chk("t2_instr", instruction_o, 32'hC0DE_0017);
            end else instr_ready_i = 1'b1;
            tick;
            n++;
        end
        wait_ok("t2_wait", n);
        r0 = req_log.size();
        instr_ready_i = 1'b1;
        n = 0;
        while (req_log.size() <= r0 && n < 200) begin tick; n++; end
        wait_ok("t2_wait_req", n);
        chk("t2_next_addr", q_at(req_log, r0), 32'h8);

        // redirect while a delayed request is outstanding
        do_reset;
        n = 0;
        while (!(instr_valid_o && instr_pc_o == 32'h4) && n < 200) begin tick; n++; end
        wait_ok("t3_wait_hold", n);
        lat = 3;
        n = 0;
        while (!(imem_req_o && imem_addr_o == 32'h8) && n < 200) begin tick; n++; end
        wait_ok("t3_wait_req", n);
        chk("t3_no_ack", 32'(imem_ack_i), 32'd0);
        redir(32'h100);
        n = 0;
        while (!(imem_req_o && imem_addr_o == 32'h100) && n < 200) begin
            if (imem_req_o) chk("t3_old_addr", imem_addr_o, 32'h8);
            tick;
            n++;
        end
        wait_ok("t3_wait_new", n);
        lat = 0;
        n = 0;
        while (xfer_pc.size() < 3 && n < 200) begin tick; n++; end
        wait_ok("t3_wait_xfer", n);
        chk("t3_xfer", q_at(xfer_pc, 2), 32'h100);
        c = 0;
        foreach (xfer_pc[i]) if (xfer_pc[i] == 32'h8) c++;
        chk("t3_stale_dropped", 32'(c), 32'd0);

        // redirect coincident with ack
        do_reset;
        n = 0;
        while (!(imem_req_o && imem_ack_i && imem_addr_o == 32'h8) && n < 200) begin tick; n++; end
        wait_ok("t4_wait", n);
        redir(32'h200);
        chk("t4_gap_req", 32'(imem_req_o), 32'd0);
        chk("t4_gap_valid", 32'(instr_valid_o), 32'd0);
        tick;
        chk("t4_req", 32'(imem_req_o), 32'd1);
        chk("t4_addr", imem_addr_o, 32'h200);
        n = 0;
        while (xfer_pc.size() < 3 && n < 200) begin tick; n++; end
        wait_ok("t4_wait_xfer", n);
        chk("t4_xfer", q_at(xfer_pc, 2), 32'h200);

        // redirect in HOLD while decode accepts
        do_reset;
        n = 0;
        while (!(instr_valid_o && instr_pc_o == 32'h4) && n < 200) begin tick; n++; end
        wait_ok("t5_wait", n);
        redir(32'h300);
        chk("t5_valid_low", 32'(instr_valid_o), 32'd0);
        chk("t5_req", 32'(imem_req_o), 32'd1);
        chk("t5_addr", imem_addr_o, 32'h300);
        n = 0;
        while (xfer_pc.size() < 3 && n < 200) begin tick; n++; end
        wait_ok("t5_wait_xfer", n);
        chk("t5_x1", q_at(xfer_pc, 1), 32'h4);
        chk("t5_x2", q_at(xfer_pc, 2), 32'h300);
        c = 0;
        foreach (xfer_pc[i]) if (xfer_pc[i] == 32'h4) c++;
        chk("t5_once", 32'(c), 32'd1);

        // pc wrap at the top of the address space
        do_reset;
        n = 0;
        while (!(instr_valid_o && instr_pc_o == 32'h0) && n < 200) begin tick; n++; end
        wait_ok("t6_wait", n);
        redir(32'hFFFF_FFF8);
        n = 0;
        while (xfer_pc.size() < 4 && n < 200) begin tick; n++; end
        wait_ok("t6_wait_xfer", n);
        chk("t6_x1", q_at(xfer_pc, 1), 32'hFFFF_FFF8);
        chk("t6_x2", q_at(xfer_pc, 2), 32'hFFFF_FFFC);
        chk("t6_x3", q_at(xfer_pc, 3), 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        // misaligned redirect traps and sticks
        do_reset;
        n = 0;
        while (!(instr_valid_o && instr_pc_o == 32'h0) && n < 200) begin tick; n++; end
        wait_ok("t7_wait", n);
        redir(32'h102);
        chk("t7_mis", 32'(fetch_misaligned_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t7_req_low", 32'(imem_req_o), 32'd0);
            tick;
        end
        redir(32'h200);
        tick;
        chk("t7_ignored_req", 32'(imem_req_o), 32'd0);
        chk("t7_ignored_valid", 32'(instr_valid_o), 32'd0);
        chk("t7_sticky", 32'(fetch_misaligned_o), 32'd1);
`endif

        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
